// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants shared by the timing generator, shape generators and game logic
package vga_pkg;
  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;
  localparam logic H_SYNC_POL = 1'b0;
  localparam logic V_SYNC_POL = 1'b0;
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
  typedef logic [9:0] coord_t;
endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster position and sync bundle from the timing generator to pixel consumers
interface vga_timing_gen_if;
  import vga_pkg::*;
  coord_t X_pix;
  coord_t Y_pix;
  logic hsync;
  logic vsync;
  logic video_on;
  logic frame_start;
  logic vblank_start;
  modport master (output X_pix, Y_pix, hsync, vsync, video_on, frame_start, vblank_start);
  modport slave  (input  X_pix, Y_pix, hsync, vsync, video_on, frame_start, vblank_start);
endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: wrapping 0..TERMINAL counter with enable, exposing next value and wrap strobe
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned TERMINAL = H_TOTAL - 1
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   en,
  output coord_t count,
  output coord_t count_next,
  output logic   wrap
);
  coord_t count_q, count_d;
  // reset parks on TERMINAL so the first enabled cycle after release lands on 0
  always_comb begin
    count_d = !reset_n ? coord_t'(TERMINAL) : !en ? count_q : (count_q == coord_t'(TERMINAL)) ? '0 : count_q + 10'd1;
  end
  // counter state
  always_ff @(posedge clk) begin
    count_q <= count_d;
  end
  assign count      = count_q;
  assign count_next = count_d;
  assign wrap       = reset_n && en && (count_q == coord_t'(TERMINAL));
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: registered raster position, syncs, video enable and frame strobes on the pixel clock
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = vga_pkg::H_VISIBLE,
  parameter int unsigned H_FRONT    = vga_pkg::H_FRONT,
  parameter int unsigned H_SYNC     = vga_pkg::H_SYNC,
  parameter int unsigned H_BACK     = vga_pkg::H_BACK,
  parameter int unsigned V_VISIBLE  = vga_pkg::V_VISIBLE,
  parameter int unsigned V_FRONT    = vga_pkg::V_FRONT,
  parameter int unsigned V_SYNC     = vga_pkg::V_SYNC,
  parameter int unsigned V_BACK     = vga_pkg::V_BACK,
  parameter logic        H_SYNC_POL = vga_pkg::H_SYNC_POL,
  parameter logic        V_SYNC_POL = vga_pkg::V_SYNC_POL
) (
  input logic pixel_clk,
  input logic reset_n,
  vga_timing_gen_if.master vga
);
  localparam int unsigned HT  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VT  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HSS = H_VISIBLE + H_FRONT;
  localparam int unsigned HSE = HSS + H_SYNC;
  localparam int unsigned VSS = V_VISIBLE + V_FRONT;
  localparam int unsigned VSE = VSS + V_SYNC;
  if (HT > 1024 || VT > 1024) begin : g_bad_totals
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must fit in 10 bits");
  end
  coord_t x_next, y_next;
  logic h_wrap, v_wrap;
  logic hsync_q, hsync_d, vsync_q, vsync_d, video_on_q, video_on_d;
  logic frame_start_q, frame_start_d, vblank_start_q, vblank_start_d;
  vga_axis_counter #(.TERMINAL(HT - 1)) u_h (
    .clk(pixel_clk), .reset_n(reset_n), .en(1'b1),
    .count(vga.X_pix), .count_next(x_next), .wrap(h_wrap)
  );
  vga_axis_counter #(.TERMINAL(VT - 1)) u_v (
    .clk(pixel_clk), .reset_n(reset_n), .en(h_wrap),
    .count(vga.Y_pix), .count_next(y_next), .wrap(v_wrap)
  );
  // decode from the next coordinates so every output describes the same pixel as X_pix/Y_pix
  always_comb begin
    hsync_d        = (x_next >= coord_t'(HSS) && x_next < coord_t'(HSE)) ? H_SYNC_POL : !H_SYNC_POL;
    vsync_d        = (y_next >= coord_t'(VSS) && y_next < coord_t'(VSE)) ? V_SYNC_POL : !V_SYNC_POL;
    video_on_d     = (x_next < coord_t'(H_VISIBLE)) && (y_next < coord_t'(V_VISIBLE));
    frame_start_d  = v_wrap;
    vblank_start_d = (x_next == '0) && (y_next == coord_t'(V_VISIBLE));
  end
  // output registers
  always_ff @(posedge pixel_clk) begin
    hsync_q        <= hsync_d;
    vsync_q        <= vsync_d;
    video_on_q     <= video_on_d;
    frame_start_q  <= frame_start_d;
    vblank_start_q <= vblank_start_d;
  end
  assign vga.hsync        = hsync_q;
  assign vga.vsync        = vsync_q;
  assign vga.video_on     = video_on_q;
  assign vga.frame_start  = frame_start_q;
  assign vga.vblank_start = vblank_start_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for a full-size 640x480 instance and a shrunken-timing instance
module tb_vga_timing_gen;
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic hs, vs, vo, fs, vb;
  } obs_t;

  logic clk = 1'b0;
  logic rn_a = 1'b0;
  logic rn_b = 1'b0;
  always #20 clk = ~clk;

  vga_timing_gen_if ia ();
  vga_timing_gen_if ib ();

  vga_timing_gen dut_a (.pixel_clk(clk), .reset_n(rn_a), .vga(ia));
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0)
  ) dut_b (.pixel_clk(clk), .reset_n(rn_b), .vga(ib));

  obs_t qa[$];
  obs_t qb[$];
  int n_assert = 0;
  int n_fail = 0;
  int ax = 0, ay = 0, bx = 0, by = 0;
  int cyc = 0, last_fs = -1, vs_low = 0, vb_cnt = 0, frames_b = 0;
  bit frame_ok = 0;

  function automatic obs_t model(int x, int y, int hv, int hf, int hs, int vv, int vf, int vs, bit hp, bit vp);
    obs_t e;
    e.x  = 10'(x);
    e.y  = 10'(y);
    e.hs = (x >= hv + hf && x < hv + hf + hs) ? hp : ~hp;
    e.vs = (y >= vv + vf && y < vv + vf + vs) ? vp : ~vp;
    e.vo = (x < hv) && (y < vv);
    e.fs = (x == 0) && (y == 0);
    e.vb = (x == 0) && (y == vv);
    return e;
  endfunction

  function automatic obs_t grab_a();
    return {ia.X_pix, ia.Y_pix, ia.hsync, ia.vsync, ia.video_on, ia.frame_start, ia.vblank_start};
  endfunction

  function automatic obs_t grab_b();
    return {ib.X_pix, ib.Y_pix, ib.hsync, ib.vsync, ib.video_on, ib.frame_start, ib.vblank_start};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    if (!rn_a) begin ax = 799; ay = 524; end
    else if (ax == 799) begin ax = 0; ay = (ay == 524) ? 0 : ay + 1; end
    else ax++;
    if (!rn_b) begin bx = 15; by = 10; end
    else if (bx == 15) begin bx = 0; by = (by == 10) ? 0 : by + 1; end
    else bx++;
    qa.push_back(model(ax, ay, 640, 16, 96, 480, 10, 2, 1'b0, 1'b0));
    qb.push_back(model(bx, by, 8, 2, 3, 6, 1, 2, 1'b1, 1'b0));
    @(posedge clk);
    #1;
    cyc++;
    check("scan_a", 32'(grab_a()), 32'(qa.pop_front()));
    check("scan_b", 32'(grab_b()), 32'(qb.pop_front()));
    if (!rn_b) begin
      frame_ok = 0;
      last_fs = -1;
    end else begin
      if (ib.frame_start) begin
        if (frame_ok) begin
          check("vsync_low_per_frame_b", vs_low, 32);
          check("vblank_per_frame_b", vb_cnt, 1);
          frames_b++;
        end
        if (last_fs >= 0) check("frame_period_b", cyc - last_fs, 176);
        last_fs = cyc;
        frame_ok = 1;
        vs_low = 0;
        vb_cnt = 0;
      end
      if (!ib.vsync) vs_low++;
      if (ib.vblank_start) begin
        vb_cnt++;
        check("vblank_pos_b", {ib.X_pix, ib.Y_pix}, {10'd0, 10'd6});
      end
    end
  endtask

  task automatic run_a(input int x, input int y);
    for (int i = 0; i < 9000 && !(ia.X_pix == 10'(x) && ia.Y_pix == 10'(y)); i++) tick();
    check("reach_a", {ia.X_pix, ia.Y_pix}, {10'(x), 10'(y)});
  endtask

  task automatic run_b(input int x, input int y);
    for (int i = 0; i < 400 && !(ib.X_pix == 10'(x) && ib.Y_pix == 10'(y)); i++) tick();
    check("reach_b", {ib.X_pix, ib.Y_pix}, {10'(x), 10'(y)});
  endtask

  initial begin
    repeat (3) tick();
    check("rst_x", ia.X_pix, 799);
    check("rst_y", ia.Y_pix, 524);
    check("rst_hsync", ia.hsync, 1);
    check("rst_vsync", ia.vsync, 1);
    check("rst_video_on", ia.video_on, 0);
    check("rst_frame_start", ia.frame_start, 0);
    check("rst_vblank_start", ia.vblank_start, 0);
    rn_a = 1'b1;
    rn_b = 1'b1;
    tick();
    check("first_xy", {ia.X_pix, ia.Y_pix}, 0);
    check("first_video_on", ia.video_on, 1);
    check("first_frame_start", ia.frame_start, 1);
    run_a(639, 0);
    check("video_on_639", ia.video_on, 1);
    tick();
    check("video_on_640", ia.video_on, 0);
    run_a(655, 0);
    check("hsync_655", ia.hsync, 1);
    tick();
    check("hsync_656", ia.hsync, 0);
    run_a(751, 0);
    check("hsync_751", ia.hsync, 0);
    tick();
    check("hsync_752", ia.hsync, 1);
    run_a(799, 5);
    check("wrap_pre_y", ia.Y_pix, 5);
    tick();
    check("wrap_post_xy", {ia.X_pix, ia.Y_pix}, {10'd0, 10'd6});
    run_a(300, 10);
    rn_a = 1'b0;
    tick();
    check("midrst_xy", {ia.X_pix, ia.Y_pix}, {10'd799, 10'd524});
    check("midrst_syncs", {ia.hsync, ia.vsync}, 2'b11);
    check("midrst_frame_start", ia.frame_start, 0);
    rn_a = 1'b1;
    tick();
    check("midrst_release_xy", {ia.X_pix, ia.Y_pix}, 0);
    check("midrst_release_fs", ia.frame_start, 1);
    run_b(5, 3);
    rn_b = 1'b0;
    tick();
    check("midrst_b_xy", {ib.X_pix, ib.Y_pix}, {10'd15, 10'd10});
    check("midrst_b_syncs", {ib.hsync, ib.vsync}, 2'b01);
    rn_b = 1'b1;
    tick();
    check("midrst_b_release_xy", {ib.X_pix, ib.Y_pix}, 0);
    check("midrst_b_release_fs", ib.frame_start, 1);
    repeat (400) tick();
    check("frames_seen_b", frames_b >= 2, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
